// File: rtl/lane_queue_tracker.sv
// lane_queue_tracker: per-lane car queue counts fed by arrival edges, drained on green; `LANE_QUEUE_TOTAL_EN adds a registered sum output.
module lane_queue_tracker #(
  parameter int NUM_LANES = 8,
  parameter int COUNT_W = 8,
  parameter int DEPART_INTERVAL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_LANES-1:0] arrive,
  input  logic [NUM_LANES-1:0] laneOutput,
  output logic [NUM_LANES-1:0][COUNT_W-1:0] lane,
  output logic [NUM_LANES-1:0] empty,
`ifdef LANE_QUEUE_TOTAL_EN
  output logic [COUNT_W+$clog2(NUM_LANES)-1:0] total,
`endif
  output logic [NUM_LANES-1:0] overflow
);
  localparam int TW = DEPART_INTERVAL > 1 ? $clog2(DEPART_INTERVAL) : 1;
  logic [NUM_LANES-1:0][COUNT_W-1:0] lane_q, lane_d;
  logic [NUM_LANES-1:0][TW-1:0] tmr_q, tmr_d;
  logic [NUM_LANES-1:0] arrive_q, ovf_q, ovf_d, arr, dep, run, sat;
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      arr[i] = arrive[i] & ~arrive_q[i];
      run[i] = laneOutput[i] && lane_q[i] != '0;
      dep[i] = run[i] && tmr_q[i] == TW'(DEPART_INTERVAL - 1);
      tmr_d[i] = (!run[i] || dep[i]) ? '0 : tmr_q[i] + 1'b1;
      sat[i] = lane_q[i] == '1;
      lane_d[i] = (arr[i] && !dep[i]) ? (sat[i] ? lane_q[i] : lane_q[i] + 1'b1) :
                  (!arr[i] && dep[i]) ? lane_q[i] - 1'b1 : lane_q[i];
      ovf_d[i] = ovf_q[i] | (arr[i] & ~dep[i] & sat[i]);
      empty[i] = lane_q[i] == '0;
    end
  end
  // Sensor history tracks the level even through reset, so a sensor held high across reset release is not an edge.
  always_ff @(posedge clk) begin
    arrive_q <= arrive;
    if (rst) begin
      lane_q <= '0;
      tmr_q <= '0;
      ovf_q <= '0;
    end else begin
      lane_q <= lane_d;
      tmr_q <= tmr_d;
      ovf_q <= ovf_d;
    end
  end
  assign lane = lane_q;
  assign overflow = ovf_q;
`ifdef LANE_QUEUE_TOTAL_EN
  localparam int TOT_W = COUNT_W + $clog2(NUM_LANES);
  localparam int LV = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
  localparam int P = 1 << LV;
  logic [TOT_W-1:0] node [P];
  logic [TOT_W-1:0] total_q, total_d;
  // Pairwise in-place reduction over a power-of-two padded leaf set.
  always_comb begin
    for (int j = 0; j < P; j++) node[j] = j < NUM_LANES ? TOT_W'(lane_d[j]) : '0;
    for (int w = P / 2; w >= 1; w = w / 2)
      for (int j = 0; j < w; j++) node[j] = node[2*j] + node[2*j+1];
    total_d = node[0];
  end
  always_ff @(posedge clk) total_q <= rst ? '0 : total_d;
  assign total = total_q;
`endif
endmodule
